// File: rtl/room_occupancy_controller.sv
// Automatic room light controller: decodes a two-beam doorway sensor into entry/exit
// events, tracks a saturating occupancy count and holds the light after the room empties.
module room_occupancy_controller #(
    parameter int OCC_W       = 8,
    parameter int MAX_OCC     = 255,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beam_a,
    input  logic             beam_b,
    output logic             light,
    output logic [OCC_W-1:0] occupancy,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             full
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [OCC_W-1:0] MAX_V  = OCC_W'(MAX_OCC);
    localparam logic [TW-1:0]    TMO_V  = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0]    HOLD_V = HW'(HOLD_CYCLES);

    typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             light_q, light_d;
    logic             entry_q, exit_q;
    logic             done_entry, done_exit;
    logic [1:0]       ab;

    assign ab = {beam_a, beam_b};

    always_comb begin
        state_d    = state_q;
        done_entry = 1'b0;
        done_exit  = 1'b0;
        case (state_q)
            IDLE: if (ab == 2'b10) state_d = E1;
                  else if (ab == 2'b01) state_d = X1;
            E1:   if (ab == 2'b11) state_d = E2;
                  else if (ab != 2'b10) state_d = IDLE;
            E2:   if (ab == 2'b01) state_d = E3;
                  else if (ab == 2'b10) state_d = E1;
                  else if (ab == 2'b00) state_d = IDLE;
            E3:   if (ab == 2'b00) begin
                      state_d    = IDLE;
                      done_entry = 1'b1;
                  end else if (ab == 2'b11) state_d = E2;
                  else if (ab == 2'b10) state_d = IDLE;
            X1:   if (ab == 2'b11) state_d = X2;
                  else if (ab != 2'b01) state_d = IDLE;
            X2:   if (ab == 2'b10) state_d = X3;
                  else if (ab == 2'b01) state_d = X1;
                  else if (ab == 2'b00) state_d = IDLE;
            X3:   if (ab == 2'b00) begin
                      state_d   = IDLE;
                      done_exit = 1'b1;
                  end else if (ab == 2'b11) state_d = X2;
                  else if (ab == 2'b01) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A stall in any non-IDLE state aborts silently once the count would reach TIMEOUT.
        tmo_d = '0;
        if (state_d == state_q && state_q != IDLE) begin
            if (tmo_q == TMO_V) state_d = IDLE;
            else                tmo_d   = tmo_q + 1'b1;
        end

        occ_d = occ_q;
        if (done_entry && occ_q != MAX_V) occ_d = occ_q + 1'b1;
        if (done_exit && occ_q != '0)     occ_d = occ_q - 1'b1;

        hold_d  = hold_q;
        light_d = light_q;
        if (occ_d != '0) begin
            light_d = 1'b1;
            hold_d  = '0;
        end else if (occ_q != '0) begin
            hold_d  = HOLD_V;
            light_d = (HOLD_CYCLES > 0);
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == HW'(1)) light_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            hold_q  <= '0;
            occ_q   <= '0;
            light_q <= 1'b0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            occ_q   <= occ_d;
            light_q <= light_d;
            entry_q <= done_entry;
            exit_q  <= done_exit;
        end
    end

    assign light       = light_q;
    assign occupancy   = occ_q;
    assign entry_pulse = entry_q;
    assign exit_pulse  = exit_q;
    assign full        = (occ_q == MAX_V);

endmodule

// File: tb/tb_room_occupancy_controller.sv
// Directed bench: table of per-cycle vectors for the default build, hand sequences for
// timeout, async reset, saturation and zero-hold on a second instance.
module tb_room_occupancy_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_a, m_b, a_a, a_b;
    logic       m_light, m_entry, m_exit, m_full;
    logic       a_light, a_entry, a_exit, a_full;
    logic [7:0] m_occ, a_occ;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    room_occupancy_controller u_main (
        .clk(clk), .rst(rst), .beam_a(m_a), .beam_b(m_b),
        .light(m_light), .occupancy(m_occ), .entry_pulse(m_entry),
        .exit_pulse(m_exit), .full(m_full)
    );

    room_occupancy_controller #(.MAX_OCC(3), .HOLD_CYCLES(0)) u_alt (
        .clk(clk), .rst(rst), .beam_a(a_a), .beam_b(a_b),
        .light(a_light), .occupancy(a_occ), .entry_pulse(a_entry),
        .exit_pulse(a_exit), .full(a_full)
    );

    typedef struct {
        logic a, b, ent, ext;
        int   occ;
        logic lit;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic a, input logic b, input logic en, input logic ex,
                       input int occ, input logic li);
        vec_t v;
        v.a = a; v.b = b; v.ent = en; v.ext = ex; v.occ = occ; v.lit = li;
        vecs.push_back(v);
    endtask

    task automatic step(input bit sel, input logic a, input logic b);
        if (sel) begin a_a = a; a_b = b; end
        else     begin m_a = a; m_b = b; end
        @(posedge clk); #1;
    endtask

    task automatic do_entry(input bit sel);
        step(sel, 1, 0); step(sel, 1, 1); step(sel, 0, 1); step(sel, 0, 0);
    endtask

    task automatic do_exit(input bit sel);
        step(sel, 0, 1); step(sel, 1, 1); step(sel, 1, 0); step(sel, 0, 0);
    endtask

    initial begin
        // pass in, pass out with 4-cycle hold, re-entry during hold, aborted/reversed passes
        add(0,0, 0,0,0,0); add(1,0, 0,0,0,0); add(1,1, 0,0,0,0); add(0,1, 0,0,0,0);
        add(0,0, 1,0,1,1); add(0,0, 0,0,1,1);
        add(0,1, 0,0,1,1); add(1,1, 0,0,1,1); add(1,0, 0,0,1,1);
        add(0,0, 0,1,0,1); add(0,0, 0,0,0,1); add(0,0, 0,0,0,1); add(0,0, 0,0,0,1);
        add(0,0, 0,0,0,0); add(0,0, 0,0,0,0);
        add(1,0, 0,0,0,0); add(1,1, 0,0,0,0); add(0,1, 0,0,0,0); add(0,0, 1,0,1,1);
        add(0,1, 0,0,1,1); add(1,1, 0,0,1,1); add(1,0, 0,0,1,1); add(0,0, 0,1,0,1);
        add(1,0, 0,0,0,1); add(1,1, 0,0,0,1); add(0,1, 0,0,0,1); add(0,0, 1,0,1,1);
        add(0,0, 0,0,1,1);
        add(1,0, 0,0,1,1); add(1,1, 0,0,1,1); add(1,0, 0,0,1,1); add(0,0, 0,0,1,1);
        add(1,0, 0,0,1,1); add(0,0, 0,0,1,1);
        add(1,0, 0,0,1,1); add(1,1, 0,0,1,1); add(0,1, 0,0,1,1); add(1,1, 0,0,1,1);
        add(1,0, 0,0,1,1); add(0,0, 0,0,1,1);

        rst = 1'b1; m_a = 0; m_b = 0; a_a = 0; a_b = 0;
        #12;
        chk("rst_occ", m_occ, 0);
        chk("rst_light", m_light, 0);
        chk("rst_entry", m_entry, 0);
        chk("rst_exit", m_exit, 0);
        chk("rst_full", m_full, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(0, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_entry", i), m_entry, vecs[i].ent);
            chk($sformatf("vec%0d_exit", i), m_exit, vecs[i].ext);
            chk($sformatf("vec%0d_occ", i), m_occ, vecs[i].occ);
            chk($sformatf("vec%0d_light", i), m_light, vecs[i].lit);
        end

        // beams held 11 far past the timeout: the pass is abandoned, 01,00 is then a stray X1
        step(0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1);
            chk("tmo_no_entry", m_entry, 0);
        end
        step(0, 0, 1); step(0, 0, 0);
        chk("tmo_entry", m_entry, 0);
        chk("tmo_exit", m_exit, 0);
        chk("tmo_occ", m_occ, 1);

        step(0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1);
        step(0, 0, 1); step(0, 0, 0);
        chk("slow_entry", m_entry, 1);
        chk("slow_occ", m_occ, 2);

        for (int i = 0; i < 3; i++) do_entry(0);
        chk("occ5", m_occ, 5);
        step(0, 1, 0); step(0, 1, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_occ", m_occ, 0);
        chk("arst_light", m_light, 0);
        chk("arst_entry", m_entry, 0);
        #2 rst = 1'b0;
        step(0, 0, 1); step(0, 0, 0);
        chk("post_rst_entry", m_entry, 0);
        chk("post_rst_exit", m_exit, 0);
        chk("post_rst_occ", m_occ, 0);

        // saturation at 3 and zero hold time on the second instance
        for (int k = 1; k <= 4; k++) begin
            do_entry(1);
            chk("sat_entry", a_entry, 1);
            chk("sat_occ", a_occ, (k < 3) ? k : 3);
            chk("sat_full", a_full, (k >= 3) ? 1 : 0);
            chk("sat_light", a_light, 1);
            step(1, 0, 0);
            chk("sat_entry_drop", a_entry, 0);
        end
        for (int k = 1; k <= 3; k++) begin
            do_exit(1);
            chk("dec_exit", a_exit, 1);
            chk("dec_occ", a_occ, 3 - k);
            chk("dec_light", a_light, (k < 3) ? 1 : 0);
            chk("dec_full", a_full, 0);
        end
        do_exit(1);
        chk("floor_exit", a_exit, 1);
        chk("floor_occ", a_occ, 0);
        chk("floor_light", a_light, 0);
        step(1, 0, 0);
        chk("floor_exit_drop", a_exit, 0);
        chk("floor_light_after", a_light, 0);
        chk("main_full", m_full, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
